// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: MD_* op codes, default latencies, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package md_unit_pkg;

    localparam int MD_WIDTH_DEF       = 32;
    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef enum logic {
        MD_ST_IDLE = 1'b0,
        MD_ST_RUN  = 1'b1
    } md_state_e;

    // True for the ops that go through the multi-cycle RUN state.
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_mult(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_unit_arith.sv
// Combinational mult/div datapath producing the HI/LO result for one operation.
// Latency: 0 cycles (pure combinational); the owner models timing with its own counter.
// Backpressure: none; ports: op, rs_val, rt_val in -> res_hi, res_lo, div_zero out.
module md_arith
    import md_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH_DEF
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_zero
);

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   q_u;
    logic [WIDTH-1:0]   r_u;
    logic               is_signed;
    logic               neg_q;
    logic               neg_r;

    always_comb begin
        // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
        prod_s = {{WIDTH{rs_val[WIDTH-1]}}, rs_val} * {{WIDTH{rt_val[WIDTH-1]}}, rt_val};
        prod_u = {{WIDTH{1'b0}}, rs_val} * {{WIDTH{1'b0}}, rt_val};

        // Signed divide runs on magnitudes. The most negative dividend has magnitude
        // 2^(WIDTH-1), which is still representable unsigned, so MIN/-1 yields
        // quotient 0x80..0 after re-negation with no special case.
        is_signed = (op == MD_DIV);
        neg_q     = is_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
        neg_r     = is_signed & rs_val[WIDTH-1];
        mag_a     = (is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
        mag_b     = (is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

        div_zero  = (rt_val == '0) && ((op == MD_DIV) || (op == MD_DIVU));
        // Substitute a divisor of 1 so the divider never sees zero; the result is discarded.
        divisor   = (rt_val == '0) ? WIDTH'(1) : mag_b;
        q_u       = mag_a / divisor;
        r_u       = mag_a % divisor;

        res_hi = '0;
        res_lo = '0;
        case (op)
            MD_MULT: begin
                res_hi = prod_s[2*WIDTH-1:WIDTH];
                res_lo = prod_s[WIDTH-1:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[2*WIDTH-1:WIDTH];
                res_lo = prod_u[WIDTH-1:0];
            end
            MD_DIV, MD_DIVU: begin
                res_lo = neg_q ? -q_u : q_u;
                res_hi = neg_r ? -r_u : r_u;
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Latency: MULT_CYCLES / DIV_CYCLES busy cycles, HI/LO + done the cycle after; mthi/mtlo 1 cycle.
// Backpressure: busy high while running; start during busy is ignored; flush aborts without commit.
// Ports: clk, reset (async high), start/op/rs_val/rt_val issue, flush abort, busy/done status, hi/lo.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int WIDTH       = MD_WIDTH_DEF,
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);

    md_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;
    logic             p_skip;   // divide by zero: run the full latency, but leave HI/LO alone

    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             div_zero;

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= MD_ST_IDLE;
            cnt    <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
            p_skip <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                // Flush beats both a same-cycle start and a pending commit.
                state  <= MD_ST_IDLE;
                cnt    <= '0;
                p_hi   <= '0;
                p_lo   <= '0;
                p_skip <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    MD_ST_IDLE: begin
                        if (start) begin
                            if (md_is_arith(op)) begin
                                p_hi   <= res_hi;
                                p_lo   <= res_lo;
                                p_skip <= div_zero;
                                cnt    <= md_is_mult(op) ? MULT_LAT : DIV_LAT;
                                busy   <= 1'b1;
                                state  <= MD_ST_RUN;
                            end else if (op == MD_MTHI) begin
                                hi <= rs_val;
                            end else if (op == MD_MTLO) begin
                                lo <= rs_val;
                            end
                        end
                    end
                    MD_ST_RUN: begin
                        // start is deliberately not looked at here.
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            if (!p_skip) begin
                                hi <= p_hi;
                                lo <= p_lo;
                            end
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= MD_ST_IDLE;
                        end
                    end
                    default: state <= MD_ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, flush;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        start2;
    logic [2:0]  op2;
    logic [31:0] rs2, rt2;
    logic        busy2, done2;
    logic [31:0] hi2, lo2;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q[$];
    logic [31:0] m_hi, m_lo;
    logic [31:0] m2_hi, m2_lo;

    always #5 clk = ~clk;

    md_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    md_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(32)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .op(op2), .rs_val(rs2), .rt_val(rt2),
        .flush(1'b0), .busy(busy2), .done(done2), .hi(hi2), .lo(lo2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour from the arithmetic rules, in 64-bit integer math. Returns {hi, lo}.
    function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] ch,
                                           input logic [31:0] cl);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            3'd1: begin q = sa * sb; return q; end
            3'd2: return ua * ub;
            3'd3: begin
                if (b == 0) return {ch, cl};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 0) return {ch, cl};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            3'd5: return {a, cl};
            3'd6: return {ch, a};
            default: return {ch, cl};
        endcase
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest outstanding result.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected done: hi=%0h lo=%0h with no pending op", hi, lo);
            end else begin
                e = exp_q.pop_front();
                chk("commit hi", {32'b0, hi}, {32'b0, e[63:32]});
                chk("commit lo", {32'b0, lo}, {32'b0, e[31:0]});
            end
        end
    end

    // Issue a mult/div op on dut; optionally flush at busy cycle flush_at or try a
    // stray MULT start at busy cycle intrude_at. Returns at the negedge after busy falls.
    task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int flush_at, input int intrude_at,
                          input string name);
        int n;
        logic [63:0] e;
        n = 0;
        if (flush_at == 0) begin
            e = ref_md(o, a, b, m_hi, m_lo);
            exp_q.push_back(e);
            m_hi = e[63:32];
            m_lo = e[31:0];
        end
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        start = 1'b0; op = MD_NONE;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n == flush_at) begin
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
            end
            if (n == intrude_at) begin
                start = 1'b1; op = MD_MULT; rs_val = $urandom; rt_val = $urandom;
                @(posedge clk); #1;
                start = 1'b0; op = MD_NONE;
            end
        end
        chk({name, " busy len"}, n, (flush_at != 0) ? flush_at : lat);
        chk({name, " done"}, done, (flush_at != 0) ? 0 : 1);
        if (flush_at != 0) begin
            chk({name, " hi kept"}, hi, m_hi);
            chk({name, " lo kept"}, lo, m_lo);
        end
    endtask

    // Single-cycle ops (mthi/mtlo/no-op), optionally with a same-cycle flush.
    task automatic run_quick(input logic [2:0] o, input logic [31:0] a, input logic fl,
                             input string name);
        logic [63:0] e;
        if (!fl) begin
            e = ref_md(o, a, 32'h0, m_hi, m_lo);
            m_hi = e[63:32];
            m_lo = e[31:0];
        end
        start = 1'b1; op = o; rs_val = a; rt_val = $urandom; flush = fl;
        @(posedge clk); #1;
        start = 1'b0; op = MD_NONE; flush = 1'b0;
        @(negedge clk);
        chk({name, " hi"}, hi, m_hi);
        chk({name, " lo"}, lo, m_lo);
        chk({name, " busy"}, busy, 0);
        chk({name, " done"}, done, 0);
    endtask

    task automatic run2(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input string name);
        int n;
        logic [63:0] e;
        n = 0;
        e = ref_md(o, a, b, m2_hi, m2_lo);
        m2_hi = e[63:32];
        m2_lo = e[31:0];
        start2 = 1'b1; op2 = o; rs2 = a; rt2 = b;
        @(posedge clk); #1;
        start2 = 1'b0; op2 = MD_NONE;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy2) break;
            n++;
        end
        chk({name, " busy len"}, n, lat);
        chk({name, " done"}, done2, 1);
        chk({name, " hi"}, hi2, m2_hi);
        chk({name, " lo"}, lo2, m2_lo);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b;
        int lat, fa;

        reset = 1'b1; start = 1'b0; flush = 1'b0; op = MD_NONE; rs_val = '0; rt_val = '0;
        start2 = 1'b0; op2 = MD_NONE; rs2 = '0; rt2 = '0;
        m_hi = '0; m_lo = '0; m2_hi = '0; m2_lo = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        run_md(MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, 0, 0, "mult");
        chk("mult hi const", hi, 32'hFFFF_FFFF);
        chk("mult lo const", lo, 32'hFFFF_FFFA);
        run_md(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 0, 0, "multu");
        chk("multu hi const", hi, 32'h0000_0002);
        chk("multu lo const", lo, 32'hFFFF_FFFA);
        run_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 0, 0, "div");
        chk("div hi const", hi, 32'hFFFF_FFFF);
        chk("div lo const", lo, 32'hFFFF_FFFD);
        run_md(MD_DIVU, 32'd7, 32'd2, 10, 0, 0, "divu");
        chk("divu hi const", hi, 32'd1);
        chk("divu lo const", lo, 32'd3);
        run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 0, 0, "div ovf");
        chk("div ovf hi const", hi, 32'h0);
        chk("div ovf lo const", lo, 32'h8000_0000);
        run_quick(MD_MTHI, 32'h11, 1'b0, "mthi");
        run_quick(MD_MTLO, 32'h22, 1'b0, "mtlo");
        run_md(MD_DIVU, 32'h1234, 32'h0, 10, 0, 0, "divu by zero");
        chk("div0 hi const", hi, 32'h11);
        chk("div0 lo const", lo, 32'h22);
        run_md(MD_MULT, 32'd9, 32'd9, 5, 3, 0, "flush mid");
        run_quick(MD_MTHI, 32'h5, 1'b1, "mthi flushed");
        run_md(MD_MULT, 32'd100, 32'd100, 5, 5, 0, "flush commit");
        run_quick(MD_MTLO, 32'hABCD, 1'b0, "mtlo abcd");
        run_md(MD_DIV, 32'd1000, 32'hFFFF_FFFD, 10, 0, 3, "div ignore start");
        // Issued in the done cycle of the previous op
        run_md(MD_MULT, 32'd12345, 32'd678, 5, 0, 0, "mult back2back");
        run_md(MD_DIVU, 32'hFFFF_FFFF, 32'd16, 10, 0, 0, "divu back2back");

        // Randomized ops against the reference model
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            a = rnd_val();
            b = rnd_val();
            if (o >= MD_MULT && o <= MD_DIVU) begin
                lat = (o <= MD_MULTU) ? 5 : 10;
                fa  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, lat) : 0;
                run_md(o, a, b, lat, fa, 0, "rand md");
            end else begin
                run_quick(o, a, 1'b0, "rand quick");
            end
        end

        // Asynchronous reset in the middle of a divide
        run_quick(MD_MTHI, 32'h77, 1'b0, "pre-reset mthi");
        start = 1'b1; op = MD_DIV; rs_val = 32'd50; rt_val = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; op = MD_NONE;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async rst busy", busy, 0);
        chk("async rst done", done, 0);
        chk("async rst hi", hi, 0);
        chk("async rst lo", lo, 0);
        chk("async rst cnt", dut.cnt, 0);
        chk("async rst state", dut.state, 0);
        m_hi = '0; m_lo = '0; m2_hi = '0; m2_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Non-default latencies
        run2(MD_MULT, 32'd6, 32'd7, 1, "lat1 mult");
        run2(MD_DIV, 32'd100, 32'd7, 32, "lat32 div");
        run2(MD_DIV, 32'hFFFF_FF9C, 32'd7, 32, "lat32 div neg");

        repeat (3) @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multi-cycle multiply/divide unit with HI/LO registers, used in the E stage of the pipelined MIPS core. It accepts an operation with a one-cycle start strobe, holds `busy` for a configurable number of cycles, and then commits to HI/LO. A `flush` input cancels the in-flight operation without touching HI/LO, so exceptions and interrupts can discard an E-stage mult/div. `busy` feeds the stall unit, which freezes D while a mult/div/mf/mt instruction waits on this block.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_CYCLES`, 5: busy cycles for mult/multu; must be ≥1.
- `DIV_CYCLES`, 10: busy cycles for div/divu; must be ≥1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  strobe: `op` and operands are valid this cycle.
- `op`  in  3  operation code (MD_* constants).
- `rs_val`  in  WIDTH  forwarded rs operand: dividend, or the value for mthi/mtlo.
- `rt_val`  in  WIDTH  forwarded rt operand: multiplier or divisor.
- `flush`  in  1  abort any pending operation and drop this cycle's `start`.
- `busy`  out  1  operation in flight (registered).
- `done`  out  1  one-cycle pulse in the cycle after HI/LO commit.
- `hi`  out  WIDTH  HI register (registered; read by mfhi).
- `lo`  out  WIDTH  LO register (registered; read by mflo).

## Operation
Op codes:
- MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6.
- Codes 7 and MD_NONE act as no-ops.

States are IDLE and RUN, with a down-counter `cnt` sized to `$clog2(max(MULT_CYCLES,DIV_CYCLES)+1)`.

Start in IDLE (`start`=1, `busy`=0, `flush`=0):
- mult/multu/div/divu: compute the result from the operands this cycle, latch it into the shadow registers `p_hi`/`p_lo`, load `cnt` with the op's latency, and go to RUN.
- mthi/mtlo: write `hi`/`lo` with `rs_val` at the same edge. No RUN state and no `done`.

Arithmetic:
- mult: signed 2·WIDTH product, hi=upper half, lo=lower half.
- multu: unsigned 2·WIDTH product, same split.
- div: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend. Overflow case (-2^(WIDTH-1))/(-1) gives lo=0x80000000, hi=0.
- divu: unsigned quotient and remainder.
- Divide by zero (rt_val=0): the op runs its full latency and asserts `done`, but HI/LO keep their previous values.

RUN:
- `cnt` decrements each cycle.
- On the edge where `cnt`=1, commit `p_hi`/`p_lo` to `hi`/`lo`, clear `busy`, set `done` for one cycle, and return to IDLE.

Boundary conditions:
- `start` while `busy`=1: ignored. The stall unit must not issue it; this block takes no action.
- `flush`=1 at an edge: go to IDLE, clear `busy` and `cnt`, discard `p_hi`/`p_lo`, and suppress `done`. `hi`/`lo` are unchanged.
- `flush` and `start` in the same cycle: flush wins, including for mthi/mtlo.
- `flush` in the commit cycle (`cnt`=1): the commit is cancelled.
- Reset mid-operation: everything returns to reset values immediately.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, `cnt`=0.
- Mult/div with `start` in cycle t: `busy`=1 during cycles t+1 … t+L, where L is the op's latency. In cycle t+L+1, `busy`=0, `done`=1, and the new `hi`/`lo` are visible.
- Back-to-back: a new `start` is accepted in cycle t+L+1.
- mthi/mtlo with `start` in cycle t: new value visible in t+1; `busy` stays 0.
- Stall rule for integration: D stalls when the D instruction is an MD-class instruction and either (E issues `start` with a mult/div op) or `busy`=1.

## Structure
- The shared definitions header, alongside the existing pipeline macros, holds the MD_* op codes and the default latencies.
- One sub-module, `md_arith`: purely combinational. It takes `op`, `rs_val` and `rt_val` and produces `res_hi`, `res_lo` and `div_zero`.
- `md_unit` owns the state, counter, shadow registers and HI/LO.

## Test plan
- Multiply, defaults: MULT rs=0xFFFFFFFE (-2), rt=3 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- Divide: DIV rs=-7, rt=2 -> after 10 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 7/2 -> lo=3, hi=1.
- Division corner cases: DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU x/0 with hi=0x11, lo=0x22 -> done after 10 cycles, hi/lo still 0x11/0x22.
- Flush:
  - flush at busy cycle 3 of a MULT -> busy=0 next cycle, no done, hi/lo unchanged.
  - `start`+`flush` together for MTHI 0x5 -> hi unchanged.
  - flush in the commit cycle -> no commit.
- Handshake: MTLO 0xABCD -> lo=0xABCD next cycle, busy never set. A `start` MULT during a running DIV is ignored, and the DIV result commits. A new MULT issued in the done cycle is accepted.
- Reset: assert reset asynchronously mid-DIV (between clock edges) -> busy, done, hi, lo, state and cnt all clear immediately. Run with MULT_CYCLES=1, DIV_CYCLES=32 -> busy lengths are 1 and 32.
